// File: rtl/sram_req_adapter_pkg.sv
// Shared defaults and FSM encoding for the L1 data-array request adapter.
// Pure declarations; no logic or latency of its own.
package sram_adapter_pkg;

    localparam int DEF_ADDR_WIDTH = 9;
    localparam int DEF_DATA_WIDTH = 128;
    localparam int DEF_MASK_WIDTH = 4;
    localparam int DEF_RESP_DEPTH = 3;

    typedef enum logic {
        SCRUB = 1'b0,
        RUN   = 1'b1
    } state_e;

    // Occupancy counter must be able to represent a completely full FIFO.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sram_req_adapter_resp_fifo.sv
// Generic synchronous FIFO: registered storage, head visible the cycle after push.
// Push is ignored when full and pop when empty; the producer owns flow control.
module resp_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 3,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/sram_req_adapter.sv
// Valid/ready front end for a 1-cycle single-port SRAM; zero-scrubs the array after reset.
// Read accept to resp_valid is 2 cycles; reads are credit-limited by FIFO space, never by resp_ready.
module sram_req_adapter
    import sram_adapter_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MASK_WIDTH = DEF_MASK_WIDTH,
    parameter int RESP_DEPTH = DEF_RESP_DEPTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [MASK_WIDTH-1:0] req_wmask,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  init_done,
    output logic                  sram_en,
    output logic                  sram_wmode,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [MASK_WIDTH-1:0] sram_wmask,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    input  logic [DATA_WIDTH-1:0] sram_rdata
);

    localparam int CW = count_width(RESP_DEPTH);

    state_e                state_q;
    state_e                state_d;
    logic [ADDR_WIDTH-1:0] scrub_addr_q;
    logic                  inflight_q;
    logic                  accept;
    logic                  read_credit;
    logic [CW:0]           credits_used;
    logic [CW-1:0]         count;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;

    // A read holds a credit from accept until its data leaves the FIFO,
    // so FIFO space is guaranteed before the SRAM returns data.
    assign credits_used = {{CW{1'b0}}, inflight_q} + {1'b0, count};
    assign read_credit  = (credits_used < (CW+1)'(RESP_DEPTH));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= SCRUB;
            scrub_addr_q <= '0;
            inflight_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= accept & ~req_write;
            if (state_q == SCRUB) begin
                scrub_addr_q <= scrub_addr_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        accept     = 1'b0;
        sram_en    = 1'b0;
        sram_wmode = 1'b0;
        sram_addr  = req_addr;
        sram_wmask = req_wmask;
        sram_wdata = req_wdata;
        case (state_q)
            SCRUB: begin
                sram_en    = 1'b1;
                sram_wmode = 1'b1;
                sram_addr  = scrub_addr_q;
                sram_wmask = '1;
                sram_wdata = '0;
                if (scrub_addr_q == '1) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                req_ready  = req_write | read_credit;
                accept     = req_valid & req_ready;
                sram_en    = accept;
                sram_wmode = req_write;
            end
            default: state_d = SCRUB;
        endcase
    end

    assign push       = inflight_q;
    assign pop        = resp_valid & resp_ready;
    assign resp_valid = ~empty;
    assign init_done  = (state_q == RUN);

    resp_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push),
        .push_data (sram_rdata),
        .pop       (pop),
        .head      (resp_rdata),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (!rstn) !(push && full));
    a_no_accept_in_scrub: assert property (@(posedge clk) disable iff (!rstn)
        (state_q == SCRUB) |-> !req_ready);

endmodule

// File: tb/tb_sram_req_adapter.sv
// Directed bench: request-level memory model and response queue checked every cycle,
// plus literal expectations for scrub, masking, streaming, backpressure and reset.
module tb_sram_req_adapter;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic         req_write = 1'b0;
    logic [8:0]   req_addr = '0;
    logic [3:0]   req_wmask = '0;
    logic [127:0] req_wdata = '0;
    logic         resp_valid;
    logic         resp_ready = 1'b1;
    logic [127:0] resp_rdata;
    logic         init_done;
    logic         sram_en;
    logic         sram_wmode;
    logic [8:0]   sram_addr;
    logic [3:0]   sram_wmask;
    logic [127:0] sram_wdata;
    logic [127:0] sram_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    sram_req_adapter dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wmask  (req_wmask),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .init_done  (init_done),
        .sram_en    (sram_en),
        .sram_wmode (sram_wmode),
        .sram_addr  (sram_addr),
        .sram_wmask (sram_wmask),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // SRAM macro stand-in, preloaded with garbage so the scrub is observable.
    logic [127:0] mem [512];
    initial begin
        for (int i = 0; i < 512; i++) mem[i] = {4{32'hBAD0_0000 | 32'(i)}};
    end
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_wmode) begin
                for (int l = 0; l < 4; l++)
                    if (sram_wmask[l]) mem[sram_addr][l*32 +: 32] <= sram_wdata[l*32 +: 32];
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    // Clock edges seen since reset release.
    int edges;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) edges <= 0;
        else       edges <= edges + 1;
    end

    // Request-level model: array contents and outstanding reads with due cycle.
    typedef struct { logic [127:0] data; int due; } exp_t;
    typedef struct { logic [127:0] data; int cyc; } pop_t;
    logic [127:0] ref_mem [512];
    exp_t expq[$];
    pop_t pops[$];

    always @(negedge clk) begin
        bit exp_valid;
        bit exp_ready;
        if (!rstn) begin
            chk("rst_resp_valid", resp_valid, 0);
            chk("rst_init_done", init_done, 0);
            chk("rst_req_ready", req_ready, 0);
            expq.delete();
            for (int i = 0; i < 512; i++) ref_mem[i] = '0;
        end else if (edges < 512) begin
            chk("scrub_init_done", init_done, 0);
            chk("scrub_req_ready", req_ready, 0);
            chk("scrub_resp_valid", resp_valid, 0);
            chk("scrub_en", sram_en, 1);
            chk("scrub_wmode", sram_wmode, 1);
            chk("scrub_addr", sram_addr, 128'(edges));
            chk("scrub_wmask", sram_wmask, 4'hF);
            chk("scrub_wdata", sram_wdata, 0);
        end else begin
            exp_valid = (expq.size() > 0) && (expq[0].due <= edges);
            exp_ready = req_write || (expq.size() < 3);
            chk("run_init_done", init_done, 1);
            chk("run_req_ready", req_ready, exp_ready);
            chk("run_resp_valid", resp_valid, exp_valid);
            if (exp_valid) chk("run_resp_rdata", resp_rdata, expq[0].data);
            chk("run_sram_en", sram_en, req_valid && exp_ready);
            if (req_valid && exp_ready) begin
                chk("run_sram_wmode", sram_wmode, req_write);
                chk("run_sram_addr", sram_addr, req_addr);
                if (req_write) begin
                    chk("run_sram_wmask", sram_wmask, req_wmask);
                    chk("run_sram_wdata", sram_wdata, req_wdata);
                end
            end
            if (exp_valid && resp_ready) void'(expq.pop_front());
            if (req_valid && exp_ready) begin
                if (req_write) begin
                    for (int l = 0; l < 4; l++)
                        if (req_wmask[l]) ref_mem[req_addr][l*32 +: 32] = req_wdata[l*32 +: 32];
                end else begin
                    expq.push_back('{data: ref_mem[req_addr], due: edges + 2});
                end
            end
        end
    end

    // Response log for the literal checks below.
    always @(negedge clk) begin
        if (rstn && resp_valid && resp_ready) pops.push_back('{data: resp_rdata, cyc: edges});
    end

    // Drive one request; returns the cycle it was accepted in and how long it stalled.
    task automatic send(input bit wr, input logic [8:0] a, input logic [3:0] m,
                        input logic [127:0] d, output int acc, output int stalls);
        stalls = 0;
        acc = -1;
        req_valid = 1'b1;
        req_write = wr;
        req_addr = a;
        req_wmask = m;
        req_wdata = d;
        while (1) begin
            @(negedge clk);
            if (rstn && req_ready) begin
                acc = edges;
                break;
            end
            stalls++;
            if (stalls > 700) begin
                n_checks++;
                n_fail++;
                $display("FAIL send_timeout: addr %h never accepted", a);
                break;
            end
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_pops(input int n);
        int t = 0;
        while (pops.size() < n && t < 60) begin
            @(negedge clk);
            t++;
        end
        chk("resp_count", 128'(pops.size()), 128'(n));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] pat(input int a);
        return {4{32'h1000 + 32'(a)}};
    endfunction

    initial begin
        int acc, st, acc_w, acc_r, first, nz, seen;
        logic [127:0] dd;

        repeat (3) @(posedge clk);
        #2 rstn = 1'b1;

        // Scrub: done exactly 512 cycles after release, array all zero.
        seen = -1;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            if (init_done) begin
                seen = edges;
                break;
            end
        end
        chk("init_done_cycle", 128'(seen), 512);
        nz = 0;
        for (int i = 0; i < 512; i++) if (mem[i] !== '0) nz++;
        chk("scrub_nonzero_words", 128'(nz), 0);
        @(posedge clk);
        #1;
        pops.delete();
        send(0, 9'h1A5, 4'h0, '0, acc, st);
        wait_pops(1);
        chk("scrubbed_1a5", pops[0].data, 0);

        // Masked write: lanes 0 and 2 only.
        pops.delete();
        send(1, 9'h1A5, 4'b0101, {4{32'hDEADBEEF}}, acc, st);
        send(0, 9'h1A5, 4'h0, '0, acc, st);
        wait_pops(1);
        dd = {32'h0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF};
        chk("masked_1a5", pops[0].data, dd);

        // Streaming reads: 16 back-to-back, one response per cycle.
        for (int i = 0; i < 16; i++) send(1, 9'(i), 4'hF, pat(i), acc, st);
        pops.delete();
        nz = 0;
        first = 0;
        for (int i = 0; i < 16; i++) begin
            send(0, 9'(i), 4'h0, '0, acc, st);
            if (i == 0) first = acc;
            nz += st;
        end
        chk("stream_stalls", 128'(nz), 0);
        wait_pops(16);
        for (int i = 0; i < pops.size(); i++) begin
            chk("stream_data", pops[i].data, pat(i));
            chk("stream_cycle", 128'(pops[i].cyc), 128'(first + 2 + i));
        end

        // Backpressure: three reads accepted, fourth held until space frees.
        pops.delete();
        resp_ready = 1'b0;
        nz = 0;
        for (int i = 3; i < 6; i++) begin
            send(0, 9'(i), 4'h0, '0, acc, st);
            nz += st;
        end
        chk("bp_first3_stalls", 128'(nz), 0);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr = 9'd6;
        nz = 0;
        repeat (5) begin
            @(negedge clk);
            if (req_ready) nz++;
        end
        chk("bp_extra_accepts", 128'(nz), 0);
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        send(0, 9'd6, 4'h0, '0, acc, st);
        chk("bp_resume_stalls", 128'(st), 1);
        wait_pops(4);
        for (int i = 0; i < pops.size(); i++) chk("bp_order", pops[i].data, pat(3 + i));

        // Write then read of the same address on consecutive cycles.
        pops.delete();
        send(1, 9'h010, 4'hF, 128'h1, acc_w, st);
        send(0, 9'h010, 4'h0, '0, acc_r, st);
        chk("wr_rd_back_to_back", 128'(acc_r), 128'(acc_w + 1));
        wait_pops(1);
        chk("wr_rd_data", pops[0].data, 128'h1);
        chk("wr_rd_cycle", 128'(pops[0].cyc), 128'(acc_w + 3));

        // Reset with two FIFO entries and one read in flight.
        pops.delete();
        resp_ready = 1'b0;
        for (int i = 7; i < 10; i++) send(0, 9'(i), 4'h0, '0, acc, st);
        chk("pre_rst_valid", resp_valid, 1);
        rstn = 1'b0;
        #1;
        chk("mid_rst_resp_valid", resp_valid, 0);
        chk("mid_rst_init_done", init_done, 0);
        repeat (3) @(posedge clk);
        #2 rstn = 1'b1;
        resp_ready = 1'b1;
        pops.delete();
        send(0, 9'h1A5, 4'h0, '0, acc, st);
        chk("rescrub_accept_cycle", 128'(acc), 512);
        chk("no_stale_resp", 128'(pops.size()), 0);
        send(0, 9'd7, 4'h0, '0, acc, st);
        wait_pops(2);
        chk("rescrub_1a5", pops[0].data, 0);
        chk("rescrub_7", pops[1].data, 0);

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
